// File: rtl/sonar_mmio.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// sonar_mmio : four-word MMIO window driving an HC-SR04 style ranging sensor
// Revision   : 1.0
// ---------------------------------------------------------------------------
module sonar_mmio #(
  parameter logic [11:0] BASE_ADDR      = 12'hF00,
  parameter int unsigned TRIG_CYCLES    = 1000,
  parameter int unsigned PRESCALE       = 100,
  parameter int unsigned TIMEOUT_CYCLES = 3000000,
  parameter int unsigned HOLDOFF_CYCLES = 6000000
) (
  input  logic        CLK,
  input  logic        CPU_RESETN,
  input  logic        wEn,
  input  logic [11:0] addr,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  output logic        sel,
  output logic        trig,
  input  logic        echo,
  output logic        busy
);

  localparam logic [31:0] TRIG_LAST = 32'(TRIG_CYCLES - 1);
  localparam logic [31:0] PRE_LAST  = 32'(PRESCALE - 1);
  localparam logic [31:0] TIMEOUT   = 32'(TIMEOUT_CYCLES);
  localparam logic [31:0] HOLD_LAST = 32'(HOLDOFF_CYCLES - 1);
  localparam logic [31:0] TICK_MAX  = 32'hFFFF_FFFE;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_MEASURE   = 3'd3,
    S_HOLDOFF   = 3'd4
  } state_t;

  state_t      state_q, state_d, post_state;
  logic        echo_meta_q, echo_meta_d, echo_s_q, echo_s_d;
  logic [31:0] phase_q, phase_d;
  logic [31:0] to_q, to_d, to_next;
  logic [31:0] pre_q, pre_d;
  logic [31:0] tick_q, tick_d;
  logic [31:0] dist_q, dist_d;
  logic [31:0] count_q, count_d;
  logic        valid_q, valid_d;
  logic        timeout_q, timeout_d;
  logic [31:0] dout_q, dout_d;
  logic        start;
  logic        unused_bits;

  assign sel         = (addr[11:2] == BASE_ADDR[11:2]);
  assign start       = wEn && sel && (addr[1:0] == 2'd0) && dataIn[0];
  assign busy        = (state_q != S_IDLE);
  assign trig        = (state_q == S_TRIG);
  assign dataOut     = dout_q;
  assign to_next     = to_q + 32'd1;
  assign post_state  = (HOLDOFF_CYCLES == 0) ? S_IDLE : S_HOLDOFF;
  assign unused_bits = ^dataIn[31:1];

  always_comb begin
    state_d     = state_q;
    echo_meta_d = echo;
    echo_s_d    = echo_meta_q;
    phase_d     = phase_q;
    to_d        = to_q;
    pre_d       = pre_q;
    tick_d      = tick_q;
    dist_d      = dist_q;
    count_d     = count_q;
    valid_d     = valid_q;
    timeout_d   = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_TRIG;
          valid_d   = 1'b0;
          timeout_d = 1'b0;
          phase_d   = '0;
        end
      end
      S_TRIG: begin
        if (phase_q == TRIG_LAST) begin
          state_d = S_WAIT_RISE;
          to_d    = '0;
        end else begin
          phase_d = phase_q + 32'd1;
        end
      end
      S_WAIT_RISE: begin
        to_d = to_next;
        if (echo_s_q) begin
          state_d = S_MEASURE;
          tick_d  = '0;
          pre_d   = '0;
        end else if (to_next >= TIMEOUT) begin
          state_d   = post_state;
          phase_d   = '0;
          dist_d    = 32'hFFFF_FFFF;
          timeout_d = 1'b1;
          valid_d   = 1'b0;
          count_d   = count_q + 32'd1;
        end
      end
      S_MEASURE: begin
        to_d = to_next;
        if (!echo_s_q) begin
          state_d = post_state;
          phase_d = '0;
          dist_d  = tick_q;
          valid_d = 1'b1;
          count_d = count_q + 32'd1;
        end else if (to_next >= TIMEOUT) begin
          state_d   = post_state;
          phase_d   = '0;
          dist_d    = 32'hFFFF_FFFF;
          timeout_d = 1'b1;
          valid_d   = 1'b0;
          count_d   = count_q + 32'd1;
        end else if (pre_q == PRE_LAST) begin
          pre_d = '0;
          if (tick_q != TICK_MAX) tick_d = tick_q + 32'd1;
        end else begin
          pre_d = pre_q + 32'd1;
        end
      end
      S_HOLDOFF: begin
        // A start landing on the exit edge is dropped: start only acts in IDLE.
        if (phase_q == HOLD_LAST) state_d = S_IDLE;
        else                      phase_d = phase_q + 32'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reads see pre-update register values on the same edge.
  always_comb begin
    dout_d = '0;
    if (sel) begin
      case (addr[1:0])
        2'd1:    dout_d = {29'd0, timeout_q, valid_q, busy};
        2'd2:    dout_d = dist_q;
        2'd3:    dout_d = count_q;
        default: dout_d = '0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q     <= S_IDLE;
      echo_meta_q <= 1'b0;
      echo_s_q    <= 1'b0;
      phase_q     <= '0;
      to_q        <= '0;
      pre_q       <= '0;
      tick_q      <= '0;
      dist_q      <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      echo_meta_q <= echo_meta_d;
      echo_s_q    <= echo_s_d;
      phase_q     <= phase_d;
      to_q        <= to_d;
      pre_q       <= pre_d;
      tick_q      <= tick_d;
      dist_q      <= dist_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
      dout_q      <= dout_d;
    end
  end

endmodule
`default_nettype wire
